knn_query_sequencer: RTL and testbench

//  Top-level sequencer for one kNN query. Accepts a query and seeds the distance/compare datapath

---
 rtl/knn_query_sequencer.sv | 127 ++++++++++++
 tb/tb_knn_query_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/knn_query_sequencer.sv
// Per-query sequencer: seeds the compare datapath from the prev-kNN cache,
// launches the full top-K search and commits the result back to the cache.
module knn_query_sequencer #(
  parameter int unsigned K       = 4,
  parameter int unsigned ENTRY_W = 48,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   query_valid,
  output logic                   query_ready,
  input  logic [K*ENTRY_W-1:0]   prev_knn,
  output logic                   seed_valid,
  input  logic                   seed_ready,
  output logic [ENTRY_W-1:0]     seed_entry,
  output logic [$clog2(K)-1:0]   seed_idx,
  output logic                   search_start,
  input  logic                   search_done,
  output logic                   cache_update,
  input  logic                   flush,
  output logic                   busy,
  output logic                   query_done,
  output logic [CNT_W-1:0]       query_count
);

  localparam int unsigned PTR_W = $clog2(K);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(K - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEED,
    S_START,
    S_SEARCH,
    S_COMMIT
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               cache_valid_q, cache_valid_d;
  logic               flush_pend_q, flush_pend_d;
  logic [CNT_W-1:0]   count_q, count_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      cache_valid_q <= 1'b0;
      flush_pend_q  <= 1'b0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cache_valid_q <= cache_valid_d;
      flush_pend_q  <= flush_pend_d;
      count_q       <= count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cache_valid_d = cache_valid_q;
    flush_pend_d  = flush_pend_q;
    count_d       = count_q;
    query_ready   = 1'b0;
    seed_valid    = 1'b0;
    search_start  = 1'b0;
    cache_update  = 1'b0;
    query_done    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        query_ready = 1'b1;
        if (flush) cache_valid_d = 1'b0;
        // A same-cycle flush already counts as an invalid cache for this query.
        if (query_valid) begin
          ptr_d   = '0;
          state_d = (cache_valid_q && !flush) ? S_SEED : S_START;
        end
      end
      S_SEED: begin
        seed_valid = 1'b1;
        if (flush) flush_pend_d = 1'b1;
        if (seed_ready) begin
          if (ptr_q == LAST_PTR) begin
            ptr_d   = '0;
            state_d = S_START;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      S_START: begin
        search_start = 1'b1;
        if (flush) flush_pend_d = 1'b1;
        state_d = S_SEARCH;
      end
      S_SEARCH: begin
        if (flush) flush_pend_d = 1'b1;
        if (search_done) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        cache_update  = 1'b1;
        query_done    = 1'b1;
        if (count_q != '1) count_d = count_q + 1'b1;
        cache_valid_d = ~(flush_pend_q | flush);
        flush_pend_d  = 1'b0;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    seed_entry = '0;
    if (state_q == S_SEED) begin
      for (int unsigned i = 0; i < K; i++) begin
        if (ptr_q == PTR_W'(i)) seed_entry = prev_knn[i*ENTRY_W +: ENTRY_W];
      end
    end
  end

  assign seed_idx    = ptr_q;
  assign busy        = (state_q != S_IDLE);
  assign query_count = count_q;

endmodule

// File: tb/tb_knn_query_sequencer.sv
// Directed bench for knn_query_sequencer: seeding, backpressure, flush paths,
// mid-operation reset and query-counter saturation (CNT_W reduced to 4).
module tb_knn_query_sequencer;

  localparam int unsigned K       = 4;
  localparam int unsigned ENTRY_W = 48;
  localparam int unsigned CNT_W   = 4;

  logic                 clk;
  logic                 rst_n;
  logic                 query_valid;
  logic                 query_ready;
  logic [K*ENTRY_W-1:0] prev_knn;
  logic                 seed_valid;
  logic                 seed_ready;
  logic [ENTRY_W-1:0]   seed_entry;
  logic [1:0]           seed_idx;
  logic                 search_start;
  logic                 search_done;
  logic                 cache_update;
  logic                 flush;
  logic                 busy;
  logic                 query_done;
  logic [CNT_W-1:0]     query_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [ENTRY_W-1:0] e [K];

  knn_query_sequencer #(
    .K       (K),
    .ENTRY_W (ENTRY_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .query_valid  (query_valid),
    .query_ready  (query_ready),
    .prev_knn     (prev_knn),
    .seed_valid   (seed_valid),
    .seed_ready   (seed_ready),
    .seed_entry   (seed_entry),
    .seed_idx     (seed_idx),
    .search_start (search_start),
    .search_done  (search_done),
    .cache_update (cache_update),
    .flush        (flush),
    .busy         (busy),
    .query_done   (query_done),
    .query_count  (query_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a query and advance until search_start is high (state START).
  task automatic start_query();
    int n;
    query_valid = 1'b1;
    tick();
    query_valid = 1'b0;
    seed_ready  = 1'b1;
    n = 0;
    while (!search_start && n < 20) begin
      tick();
      n++;
    end
    seed_ready = 1'b0;
    n_cmp++;
    if (search_start !== 1'b1) begin
      n_bad++;
      $display("FAIL start_query_timeout search_start=%b required 1", search_start);
    end
  endtask

  // From START: search, done, commit, back to IDLE.
  task automatic finish_search();
    tick();
    search_done = 1'b1;
    tick();
    search_done = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++; if (query_ready !== 1'b1) begin n_bad++; $display("FAIL rst_query_ready got %b req 1", query_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b req 0", busy); end
    n_cmp++; if (seed_valid !== 1'b0) begin n_bad++; $display("FAIL rst_seed_valid got %b req 0", seed_valid); end
    n_cmp++; if (query_count !== 4'd0) begin n_bad++; $display("FAIL rst_count got %0d req 0", query_count); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (query_ready !== 1'b1) begin n_bad++; $display("FAIL post_rst_ready got %b req 1", query_ready); end
  endtask

  task automatic test_first_query();
    query_valid = 1'b1;
    tick();
    query_valid = 1'b0;
    n_cmp++; if (search_start !== 1'b1) begin n_bad++; $display("FAIL q1_start got %b req 1", search_start); end
    n_cmp++; if (seed_valid !== 1'b0) begin n_bad++; $display("FAIL q1_no_seed got %b req 0", seed_valid); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL q1_busy got %b req 1", busy); end
    tick();
    n_cmp++; if (search_start !== 1'b0) begin n_bad++; $display("FAIL q1_start_pulse got %b req 0", search_start); end
    tick();
    n_cmp++; if (cache_update !== 1'b0) begin n_bad++; $display("FAIL q1_early_update got %b req 0", cache_update); end
    search_done = 1'b1;
    tick();
    search_done = 1'b0;
    n_cmp++; if (cache_update !== 1'b1) begin n_bad++; $display("FAIL q1_update got %b req 1", cache_update); end
    n_cmp++; if (query_done !== 1'b1) begin n_bad++; $display("FAIL q1_done got %b req 1", query_done); end
    tick();
    n_cmp++; if (query_done !== 1'b0) begin n_bad++; $display("FAIL q1_done_pulse got %b req 0", query_done); end
    n_cmp++; if (query_count !== 4'd1) begin n_bad++; $display("FAIL q1_count got %0d req 1", query_count); end
    n_cmp++; if (query_ready !== 1'b1) begin n_bad++; $display("FAIL q1_ready got %b req 1", query_ready); end
  endtask

  task automatic test_seed_sequence();
    query_valid = 1'b1;
    tick();
    query_valid = 1'b0;
    seed_ready  = 1'b1;
    search_done = 1'b1;  // must be ignored outside SEARCH
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (seed_valid !== 1'b1) begin n_bad++; $display("FAIL seq_valid[%0d] got %b req 1", i, seed_valid); end
      n_cmp++; if (seed_idx !== 2'(i)) begin n_bad++; $display("FAIL seq_idx[%0d] got %0d req %0d", i, seed_idx, i); end
      n_cmp++; if (seed_entry !== e[i]) begin n_bad++; $display("FAIL seq_entry[%0d] got %h req %h", i, seed_entry, e[i]); end
      tick();
    end
    seed_ready  = 1'b0;
    search_done = 1'b0;
    n_cmp++; if (search_start !== 1'b1) begin n_bad++; $display("FAIL seq_start got %b req 1", search_start); end
    n_cmp++; if (seed_valid !== 1'b0) begin n_bad++; $display("FAIL seq_valid_end got %b req 0", seed_valid); end
    finish_search();
    n_cmp++; if (query_count !== 4'd2) begin n_bad++; $display("FAIL seq_count got %0d req 2", query_count); end
  endtask

  task automatic test_seed_backpressure();
    logic ready_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int exp_idx = 0;
    query_valid = 1'b1;
    tick();
    query_valid = 1'b0;
    for (int c = 0; c < 7; c++) begin
      seed_ready = ready_pat[c];
      n_cmp++; if (seed_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d] got %b req 1", c, seed_valid); end
      n_cmp++; if (seed_idx !== 2'(exp_idx)) begin n_bad++; $display("FAIL bp_idx[%0d] got %0d req %0d", c, seed_idx, exp_idx); end
      n_cmp++; if (seed_entry !== e[exp_idx]) begin n_bad++; $display("FAIL bp_entry[%0d] got %h req %h", c, seed_entry, e[exp_idx]); end
      if (ready_pat[c]) exp_idx++;
      tick();
    end
    seed_ready = 1'b0;
    n_cmp++; if (search_start !== 1'b1) begin n_bad++; $display("FAIL bp_start got %b req 1", search_start); end
    finish_search();
    n_cmp++; if (query_count !== 4'd3) begin n_bad++; $display("FAIL bp_count got %0d req 3", query_count); end
  endtask

  task automatic test_flush_search();
    start_query();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    search_done = 1'b1;
    tick();
    search_done = 1'b0;
    n_cmp++; if (cache_update !== 1'b1) begin n_bad++; $display("FAIL fs_update got %b req 1", cache_update); end
    tick();
    query_valid = 1'b1;
    tick();
    query_valid = 1'b0;
    n_cmp++; if (seed_valid !== 1'b0) begin n_bad++; $display("FAIL fs_no_seed got %b req 0", seed_valid); end
    n_cmp++; if (search_start !== 1'b1) begin n_bad++; $display("FAIL fs_start got %b req 1", search_start); end
    finish_search();
    n_cmp++; if (query_count !== 4'd5) begin n_bad++; $display("FAIL fs_count got %0d req 5", query_count); end
  endtask

  task automatic test_flush_idle();
    query_valid = 1'b1;
    flush       = 1'b1;
    tick();
    query_valid = 1'b0;
    flush       = 1'b0;
    n_cmp++; if (seed_valid !== 1'b0) begin n_bad++; $display("FAIL fi_no_seed got %b req 0", seed_valid); end
    n_cmp++; if (search_start !== 1'b1) begin n_bad++; $display("FAIL fi_start got %b req 1", search_start); end
    finish_search();
  endtask

  task automatic test_flush_commit();
    query_valid = 1'b1;
    tick();
    query_valid = 1'b0;
    n_cmp++; if (seed_valid !== 1'b1) begin n_bad++; $display("FAIL fc_seeds got %b req 1", seed_valid); end
    seed_ready = 1'b1;
    repeat (4) tick();
    seed_ready = 1'b0;
    tick();
    search_done = 1'b1;
    tick();
    search_done = 1'b0;
    flush = 1'b1;
    n_cmp++; if (cache_update !== 1'b1) begin n_bad++; $display("FAIL fc_update got %b req 1", cache_update); end
    tick();
    flush = 1'b0;
    query_valid = 1'b1;
    tick();
    query_valid = 1'b0;
    n_cmp++; if (seed_valid !== 1'b0) begin n_bad++; $display("FAIL fc_no_seed got %b req 0", seed_valid); end
    n_cmp++; if (search_start !== 1'b1) begin n_bad++; $display("FAIL fc_start got %b req 1", search_start); end
    finish_search();
    n_cmp++; if (query_count !== 4'd8) begin n_bad++; $display("FAIL fc_count got %0d req 8", query_count); end
  endtask

  task automatic test_reset_mid_seed();
    query_valid = 1'b1;
    tick();
    query_valid = 1'b0;
    seed_ready  = 1'b1;
    tick();
    tick();
    n_cmp++; if (seed_idx !== 2'd2) begin n_bad++; $display("FAIL rm_idx got %0d req 2", seed_idx); end
    rst_n = 1'b0;
    #1;
    seed_ready = 1'b0;
    n_cmp++; if (seed_valid !== 1'b0) begin n_bad++; $display("FAIL rm_valid got %b req 0", seed_valid); end
    n_cmp++; if (seed_idx !== 2'd0) begin n_bad++; $display("FAIL rm_idx0 got %0d req 0", seed_idx); end
    n_cmp++; if (seed_entry !== '0) begin n_bad++; $display("FAIL rm_entry got %h req 0", seed_entry); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rm_busy got %b req 0", busy); end
    n_cmp++; if (query_count !== 4'd0) begin n_bad++; $display("FAIL rm_count got %0d req 0", query_count); end
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (query_ready !== 1'b1) begin n_bad++; $display("FAIL rm_ready got %b req 1", query_ready); end
    query_valid = 1'b1;
    tick();
    query_valid = 1'b0;
    n_cmp++; if (seed_valid !== 1'b0) begin n_bad++; $display("FAIL rm_no_seed got %b req 0", seed_valid); end
    n_cmp++; if (search_start !== 1'b1) begin n_bad++; $display("FAIL rm_start got %b req 1", search_start); end
    finish_search();
    n_cmp++; if (query_count !== 4'd1) begin n_bad++; $display("FAIL rm_count1 got %0d req 1", query_count); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 14; i++) begin
      start_query();
      finish_search();
    end
    n_cmp++; if (query_count !== 4'hF) begin n_bad++; $display("FAIL sat_full got %0d req 15", query_count); end
    start_query();
    tick();
    search_done = 1'b1;
    tick();
    search_done = 1'b0;
    n_cmp++; if (query_done !== 1'b1) begin n_bad++; $display("FAIL sat_done got %b req 1", query_done); end
    tick();
    n_cmp++; if (query_count !== 4'hF) begin n_bad++; $display("FAIL sat_hold got %0d req 15", query_count); end
  endtask

  initial begin
    e[0] = 48'h0A0A_0000_0001;
    e[1] = 48'h1B1B_1111_0002;
    e[2] = 48'h2C2C_2222_0003;
    e[3] = 48'h3D3D_3333_0004;
    prev_knn    = {e[3], e[2], e[1], e[0]};
    rst_n       = 1'b0;
    query_valid = 1'b0;
    seed_ready  = 1'b0;
    search_done = 1'b0;
    flush       = 1'b0;

    test_reset();
    test_first_query();
    test_seed_sequence();
    test_seed_backpressure();
    test_flush_search();
    test_flush_idle();
    test_flush_commit();
    test_reset_mid_seed();
    test_saturation();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
